// File: rtl/mem_loader.sv
// Packs the host byte stream into little-endian 32-bit words and writes one
// batch of packets into the shared packet memory while the loader holds the grant.
module mem_loader #(
    parameter int unsigned WORDS_PER_PACK  = 6,
    parameter int unsigned PACKS_PER_BATCH = 8,
    parameter int unsigned TIMEOUT         = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        OutOfData,
    input  logic        mem_grant,
    output logic [31:0] addrB,
    output logic [31:0] dataB,
    output logic        weB,
    output logic        DONE_WRITING,
    output logic        busy
);
    localparam int unsigned BATCH_WORDS = WORDS_PER_PACK * PACKS_PER_BATCH;
    localparam int unsigned WIDX_W      = (BATCH_WORDS > 1) ? $clog2(BATCH_WORDS) : 1;
    localparam int unsigned TCNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(BATCH_WORDS - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_shift;
    logic [31:0]         r_data;
    logic [WIDX_W-1:0]   r_word_idx;
    logic [TCNT_W-1:0]   r_tcnt;
    logic                r_busy;
    logic                w_grant;
    logic                w_accept;
    logic                w_abort;
    logic                w_timeout;

    assign w_grant = OutOfData & mem_grant;
    assign addrB   = {30'(r_word_idx), 2'b00};
    assign dataB   = r_data;
    assign busy    = r_busy;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Grant loss is tested first so it overrides both a same-cycle byte and a timeout.
    always_comb begin
        w_next       = r_state;
        rx_ready     = 1'b0;
        weB          = 1'b0;
        DONE_WRITING = 1'b0;
        w_accept     = 1'b0;
        w_abort      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) w_next = S_LOAD;
            end
            S_LOAD: begin
                rx_ready = 1'b1;
                if (!w_grant) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (rx_valid) begin
                    w_accept = 1'b1;
                    if (r_byte_cnt == 2'd3) w_next = S_WRITE;
                end else if (r_busy && (r_tcnt == TCNT_MAX)) begin
                    w_timeout = 1'b1;
                end
            end
            S_WRITE: begin
                if (!w_grant) begin
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    weB    = 1'b1;
                    w_next = (r_word_idx == LAST_IDX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE: begin
                DONE_WRITING = 1'b1;
                w_next       = S_HOLD;
            end
            S_HOLD: begin
                if (!OutOfData) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_word_idx <= '0;
            r_tcnt     <= '0;
            r_busy     <= 1'b0;
        end else if (w_abort || w_timeout) begin
            r_byte_cnt <= '0;
            r_word_idx <= '0;
            r_tcnt     <= '0;
            r_busy     <= 1'b0;
        end else if (w_accept) begin
            r_busy <= 1'b1;
            r_tcnt <= '0;
            if (r_byte_cnt == 2'd3) begin
                r_data     <= {rx_data, r_shift};
                r_byte_cnt <= '0;
            end else begin
                r_shift[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end else if (r_state == S_LOAD && r_busy) begin
            r_tcnt <= r_tcnt + 1'b1;
        end else if (r_state == S_WRITE) begin
            r_word_idx <= (r_word_idx == LAST_IDX) ? '0 : r_word_idx + 1'b1;
        end else if (r_state == S_DONE) begin
            r_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: table of full-batch scenarios plus
// hand-written timeout, grant-loss, HOLD and asynchronous-reset sequences.
module tb_mem_loader;
    logic        clock;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        OutOfData;
    logic        mem_grant;
    logic [31:0] addrB;
    logic [31:0] dataB;
    logic        weB;
    logic        DONE_WRITING;
    logic        busy;

    mem_loader #(
        .WORDS_PER_PACK (6),
        .PACKS_PER_BATCH(8),
        .TIMEOUT        (1024)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .OutOfData   (OutOfData),
        .mem_grant   (mem_grant),
        .addrB       (addrB),
        .dataB       (dataB),
        .weB         (weB),
        .DONE_WRITING(DONE_WRITING),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0]  base;
        int unsigned gap;
        logic [31:0] first;
        logic [31:0] last;
    } vec_t;

    wr_t         sb_q[$];
    vec_t        tbl[4];
    int          checks;
    int          errors;
    int          done_cnt;
    logic        prev_we;
    logic        prev_done;
    logic [31:0] cap_first;
    logic [31:0] cap_last;
    int unsigned mdl_cnt;
    int unsigned mdl_idx;
    logic [31:0] mdl_acc;
    bit          hs_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mdl_reset();
        mdl_cnt = 0;
        mdl_idx = 0;
        mdl_acc = '0;
        sb_q.delete();
    endtask

    // Offer one byte until accepted (bounded), then update the packing model.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        logic        got;
        int unsigned n;
        wr_t         e;
        if (hs_fail) return;
        rx_data  = b;
        rx_valid = 1'b1;
        got      = 1'b0;
        n        = 0;
        while (!got && n < 64) begin
            @(negedge clock);
            got = rx_ready;
            @(posedge clock);
            #1;
            n++;
        end
        rx_valid = 1'b0;
        if (!got) begin
            hs_fail = 1'b1;
            chk("rx_ready_wait", 32'(got), 32'd1);
            return;
        end
        mdl_acc[8*mdl_cnt +: 8] = b;
        if (mdl_cnt == 3) begin
            e.addr = 32'(mdl_idx * 4);
            e.data = mdl_acc;
            sb_q.push_back(e);
            mdl_idx = (mdl_idx == 47) ? 0 : mdl_idx + 1;
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
        repeat (gap) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic run_batch(input logic [7:0] base, input int unsigned gap,
                             input logic [31:0] ef, input logic [31:0] el);
        int          d0;
        int unsigned w;
        d0        = done_cnt;
        cap_first = 32'hDEADBEEF;
        cap_last  = 32'hDEADBEEF;
        for (int unsigned n = 0; n < 192; n++) send_byte(8'(base + n), gap);
        w = 0;
        while (done_cnt == d0 && w < 16) begin
            @(posedge clock);
            #1;
            w++;
        end
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("first_word", cap_first, ef);
        chk("last_word", cap_last, el);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("rdy_after_done", 32'(rx_ready), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic rearm();
        OutOfData = 1'b0;
        @(posedge clock);
        #1;
        OutOfData = 1'b1;
        mem_grant = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        int unsigned w;
        tbl[0] = '{base: 8'h00, gap: 0, first: 32'h03020100, last: 32'hBFBEBDBC};
        tbl[1] = '{base: 8'h00, gap: 1, first: 32'h03020100, last: 32'hBFBEBDBC};
        tbl[2] = '{base: 8'h40, gap: 0, first: 32'h43424140, last: 32'hFFFEFDFC};
        tbl[3] = '{base: 8'hA5, gap: 2, first: 32'hA8A7A6A5, last: 32'h64636261};

        checks = 0; errors = 0; done_cnt = 0;
        prev_we = 1'b0; prev_done = 1'b0; hs_fail = 1'b0;
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0;
        OutOfData = 1'b0; mem_grant = 1'b0;
        mdl_reset();

        fork
            begin : monitor
                wr_t e;
                forever begin
                    @(negedge clock);
                    if (weB) begin
                        chk("rdy_in_write", 32'(rx_ready), 32'd0);
                        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                        if (sb_q.size() != 0) begin
                            e = sb_q.pop_front();
                            chk("wr_addr", addrB, e.addr);
                            chk("wr_data", dataB, e.data);
                        end
                        if (addrB == 32'd0)   cap_first = dataB;
                        if (addrB == 32'd188) cap_last  = dataB;
                    end
                    if (DONE_WRITING) begin
                        done_cnt++;
                        chk("done_after_we", 32'(prev_we), 32'd1);
                        chk("done_1cycle", 32'(prev_done), 32'd0);
                    end
                    prev_we   = weB;
                    prev_done = DONE_WRITING;
                end
            end
        join_none

        #12;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_weB", 32'(weB), 32'd0);
        chk("rst_done", 32'(DONE_WRITING), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addrB", addrB, 32'd0);
        chk("rst_dataB", dataB, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("idle_no_grant", 32'(rx_ready), 32'd0);
        OutOfData = 1'b1;
        mem_grant = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (i != 0) rearm();
            run_batch(tbl[i].base, tbl[i].gap, tbl[i].first, tbl[i].last);
            if (i == 0) begin
                repeat (3) begin
                    @(posedge clock);
                    #1;
                    chk("hold_stale", 32'(rx_ready), 32'd0);
                end
                OutOfData = 1'b0;
                repeat (2) begin
                    @(posedge clock);
                    #1;
                    chk("hold_low", 32'(rx_ready), 32'd0);
                end
                OutOfData = 1'b1;
                w = 0;
                while (!rx_ready && w < 4) begin
                    @(posedge clock);
                    #1;
                    w++;
                end
                chk("reload_rdy", 32'(rx_ready), 32'd1);
            end
        end

        // Timeout: 10 bytes then an idle gap of exactly TIMEOUT cycles.
        rearm();
        for (int unsigned n = 0; n < 10; n++) send_byte(8'(n), 0);
        repeat (1023) @(posedge clock);
        #1;
        chk("to_busy_before", 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_stay_load", 32'(rx_ready), 32'd1);
        mdl_reset();
        run_batch(8'h40, 0, 32'h43424140, 32'hFFFEFDFC);

        // Grant loss in LOAD after 20 words.
        rearm();
        for (int unsigned n = 0; n < 80; n++) send_byte(8'(8'h80 + n), 0);
        @(posedge clock);
        #1;
        chk("gl_20_written", 32'(sb_q.size()), 32'd0);
        d0 = done_cnt;
        mem_grant = 1'b0;
        @(posedge clock);
        #1;
        chk("gl_rdy", 32'(rx_ready), 32'd0);
        chk("gl_busy", 32'(busy), 32'd0);
        chk("gl_addr", addrB, 32'd0);
        repeat (4) @(posedge clock);
        #1;
        chk("gl_idle", 32'(rx_ready), 32'd0);
        chk("gl_no_done", 32'(done_cnt - d0), 32'd0);
        mdl_reset();
        mem_grant = 1'b1;
        run_batch(8'h20, 0, 32'h23222120, 32'hDFDEDDDC);

        // Grant loss during the WRITE cycle.
        rearm();
        for (int unsigned n = 0; n < 4; n++) send_byte(8'(8'h10 + n), 0);
        mem_grant = 1'b0;
        mdl_reset();
        @(negedge clock);
        chk("glw_weB", 32'(weB), 32'd0);
        @(posedge clock);
        #1;
        chk("glw_rdy", 32'(rx_ready), 32'd0);
        chk("glw_busy", 32'(busy), 32'd0);
        mem_grant = 1'b1;

        // Async reset mid-word (byte_cnt==2).
        rearm();
        for (int unsigned n = 0; n < 2; n++) send_byte(8'(8'h70 + n), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rdy", 32'(rx_ready), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_weB", 32'(weB), 32'd0);
        mdl_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_batch(8'h00, 0, 32'h03020100, 32'hBFBEBDBC);

        // Async reset while a write is in flight.
        rearm();
        for (int unsigned n = 0; n < 4; n++) send_byte(8'(8'h55 + n), 0);
        chk("arw_we_pre", 32'(weB), 32'd1);
        #2;
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("arw_weB", 32'(weB), 32'd0);
        chk("arw_addr", addrB, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream fill stage for the data manager: takes the host byte stream (UART receiver output) and packs little-endian bytes into 32-bit words.
- Writes those words sequentially into the shared packet memory through its write port.
- Pulses DONE_WRITING once a full batch of option-parameter packets is resident.
- Owns memory only while the data manager reports OutOfData and grants the loader address mux (addrSelect==1).

Parameters:
- WORDS_PER_PACK, 6, 32-bit words per packet (192-bit packet).
- PACKS_PER_BATCH, 8, packets per batch; BATCH_WORDS = WORDS_PER_PACK*PACKS_PER_BATCH (48).
- TIMEOUT, 1024, idle cycles allowed between bytes inside a batch before the batch is discarded.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  loader accepts byte; a transfer occurs when rx_valid&&rx_ready at posedge.
- OutOfData  input  1  data manager has no batch loaded.
- mem_grant  input  1  high when data manager addrSelect==2'd1.
- addrB  output  32  byte address of write, {word_idx,2'b00}.
- dataB  output  32  assembled word.
- weB  output  1  memory write enable, one cycle per word.
- DONE_WRITING  output  1  one-cycle pulse, batch complete.
- busy  output  1  loader has accepted at least one byte of the current batch.

Behaviour:
- Reset: state=IDLE; rx_ready=0, weB=0, DONE_WRITING=0, busy=0, addrB=0, dataB=0; byte_cnt, word_idx and timeout counter cleared.
- States: IDLE, LOAD, WRITE, DONE, HOLD.
- IDLE: rx_ready=0. Go to LOAD when OutOfData&&mem_grant.
- LOAD:
  - rx_ready=1.
  - Each accepted byte goes to shift position byte_cnt (byte 0 -> bits[7:0] ... byte 3 -> bits[31:24]); byte_cnt increments.
  - When the accepted byte is byte 3: register the word into dataB, byte_cnt->0, go to WRITE.
- WRITE:
  - Exactly one cycle: weB=1, addrB={word_idx,2'b00}, rx_ready=0.
  - Next state: if word_idx==BATCH_WORDS-1, go to DONE with word_idx cleared; else word_idx+1 and back to LOAD.
  - Write latency: weB asserted the cycle after the 4th byte handshake.
- DONE: DONE_WRITING=1 for exactly one cycle, rx_ready=0, busy cleared; go to HOLD.
- HOLD: rx_ready=0. Wait for OutOfData==0 (data manager entered its has-data state), then go to IDLE. This prevents re-entering LOAD on the stale OutOfData cycle.
- busy: set on the first accepted byte of a batch; cleared in DONE or on any abort.
- Timeout:
  - In LOAD with busy=1, the counter increments on every cycle without a byte handshake and clears on a handshake.
  - When it reaches TIMEOUT-1: discard the partial word and batch (byte_cnt=0, word_idx=0, busy=0), stay in LOAD. No DONE_WRITING.
  - With busy=0 the counter is held at 0.
- Grant loss: mem_grant==0 or OutOfData==0 while in LOAD or WRITE → abort to IDLE; counters cleared, weB forced 0 that cycle, no DONE_WRITING.
- Grant loss takes precedence over a simultaneous byte handshake (byte dropped) and over timeout.
- Already-written words are not erased; a later batch overwrites from address 0.
- Reset mid-operation: immediate return to reset values; a write in flight is cancelled (weB deasserts asynchronously).
- addrB width: word_idx needs $clog2(BATCH_WORDS) bits, zero-extended; addrB never exceeds (BATCH_WORDS-1)*4 = 188.

Test Plan:
- Normal fill:
  - Stimulus: OutOfData=1, mem_grant=1, stream bytes 0x00..0xBF back-to-back.
  - Required: 48 writes; first addrB=0 with dataB=0x03020100; last addrB=188 with dataB=0xBFBEBDBC.
  - DONE_WRITING one-cycle pulse the cycle after the last weB; rx_ready=0 afterwards.
- Handshake stall:
  - Stimulus: rx_valid toggles every other cycle.
  - Required: bytes packed correctly; weB exactly one cycle per 4 accepted bytes; rx_ready=0 during each WRITE cycle.
- Timeout:
  - Stimulus: send 10 bytes, then idle TIMEOUT cycles, then send 192 bytes 0x40+n.
  - Required: busy drops after the timeout; first write after recovery at addrB=0 with dataB=0x43424140; single DONE_WRITING at the end.
- Grant loss:
  - Stimulus: drop mem_grant after 20 words.
  - Required: state IDLE, no DONE_WRITING.
  - On re-grant, a full 192-byte resend writes from addrB=0.
- HOLD interlock:
  - Stimulus: keep OutOfData=1 for 3 cycles after DONE_WRITING, then 0, then 1 again.
  - Required: rx_ready stays 0 until OutOfData rises again; then a new batch loads.
- Async reset:
  - Stimulus: assert reset mid-word (byte_cnt=2) between clock edges.
  - Required: weB, rx_ready, busy drop immediately; the next batch starts at addrB=0 with byte_cnt=0.
